// File: rtl/load_store_unit_if.sv
// Core-side request/response channel and word-wide data-memory port of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_rstrb;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_busy;

  // Core and memory model side
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata, mem_busy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata, mem_busy,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: legality check, byte-lane write masks, load extraction,
// one response per request, stalls on mem_busy.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input logic              CLK,
  input logic              resetn,
  load_store_unit_if.slave bus
);
  localparam int unsigned WORD_W = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic              rstrb_q;
  logic [3:0]        wmask_q;
  logic [WORD_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              legal_c;
  logic [3:0]        wmask_c;
  logic [31:0]       wdata_c;

  // Size/alignment and funct3 legality of the presented request
  always_comb begin
    legal_c = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00:   legal_c = 1'b1;
      2'b01:   legal_c = ~bus.req_addr[0];
      2'b10:   legal_c = (bus.req_addr[1:0] == 2'b00);
      default: legal_c = 1'b0;
    endcase
    if (bus.req_funct3[2] && (bus.req_store || bus.req_funct3[1:0] == 2'b10)) legal_c = 1'b0;
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    wmask_c = 4'b1111;
    wdata_c = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        wmask_c = 4'b0001 << bus.req_addr[1:0];
        wdata_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wmask_c = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        wmask_c = 4'b1111;
        wdata_c = bus.req_wdata;
      end
    endcase
  end

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   extract = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   extract = {{16{h[15] & ~f3[2]}}, h};
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state       <= S_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rstrb_q     <= 1'b0;
      wmask_q     <= 4'b0000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
    end else begin
      rstrb_q     <= 1'b0;
      wmask_q     <= 4'b0000;
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            store_q  <= bus.req_store;
            funct3_q <= bus.req_funct3;
            lane_q   <= bus.req_addr[1:0];
            if (legal_c) begin
              state   <= S_ISSUE;
              addr_q  <= bus.req_addr[ADDR_W-1:2];
              rstrb_q <= ~bus.req_store;
              if (bus.req_store) begin
                wmask_q <= wmask_c;
                wdata_q <= wdata_c;
              end
            end else begin
              // Illegal requests answer immediately without touching memory
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (!bus.mem_busy) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= store_q ? 32'h0 : extract(funct3_q, lane_q, bus.mem_rdata);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = resetn && (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rstrb = rstrb_q;
  assign bus.mem_wmask = wmask_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage for the multi-cycle RISC-V core. It consumes load/store requests produced by the core's EXECUTE state (address = rs1+imm, funct3, rs2 data) and drives a word-wide data-memory port with byte write masks. It extracts and sign- or zero-extends load data, flags misaligned or illegal accesses, and returns one response per request through a valid/ready handshake. It stalls for any number of memory busy cycles.

## Interface
- ADDR_W, default 32: request address width; memory word address is ADDR_W-2 bits.
- CLK  in  1  system clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; 1 only in IDLE with resetn high.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  one-cycle pulse; response fields valid this cycle only.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal funct3; no memory access made.
- mem_addr  out  ADDR_W-2  word address (req_addr[ADDR_W-1:2]), registered.
- mem_rstrb  out  1  one-cycle read strobe.
- mem_wmask  out  4  one-cycle byte write enables; 0 when not writing.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word; valid in the first cycle mem_busy is low after the strobe.
- mem_busy  in  1  memory not yet done; sampled from the cycle after the strobe.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Accept = req_valid & req_ready at a rising edge. On accept, the unit registers store, funct3, addr, and wdata.
- Legality check on accept:
  - Load funct3 must be in {000, 001, 010, 100, 101}.
  - Store funct3 must be in {000, 001, 010}.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
- IDLE -> RESP on an illegal accept (rsp_err=1). IDLE -> ISSUE on a legal accept. IDLE holds otherwise.
- ISSUE (exactly 1 cycle):
  - Load: mem_rstrb=1.
  - Store: mem_wmask is
    - SB: 4'b0001 << addr[1:0]
    - SH: addr[1] ? 1100 : 0011
    - SW: 1111
  - mem_wdata is
    - SB: {4{wdata[7:0]}}
    - SH: {2{wdata[15:0]}}
    - SW: wdata
  - Next state: WAIT.
- WAIT: while mem_busy=1, hold. When mem_busy=0, capture the extracted data and go to RESP.
- Load extraction from mem_rdata:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - funct3[2]=0: sign-extend. funct3[2]=1: zero-extend.
  - LW: the word unchanged.
- RESP (exactly 1 cycle): rsp_valid=1, then IDLE. The core must capture the response in this cycle; there is no back-pressure on responses.
- mem_addr and mem_wdata hold their last value outside ISSUE. mem_rstrb and mem_wmask are 0 outside ISSUE.
- Reset (resetn low at an edge), from any state including mid-transaction:
  - State goes to IDLE; the pending transaction is dropped and no strobe is issued after reset.
  - Outputs become: rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rstrb=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
  - req_ready=0 while resetn is low.

## Timing
- Legal access, zero-wait memory (T0 = accept edge):
  - ISSUE in cycle T0+1.
  - WAIT in T0+2, with mem_busy=0.
  - RESP in T0+3.
  - req_ready high again in T0+4.
- Each busy cycle adds 1 to this latency.
- Illegal access: rsp_valid=1, rsp_err=1 in T0+1; req_ready high in T0+2.
- Throughput: at most one request in flight. req_valid while req_ready=0 is ignored and not queued.
- mem_rdata is sampled only in WAIT on the cycle mem_busy=0. mem_busy during ISSUE is ignored.

## Test plan
- LB and LBU at addr 0x13 with mem_rdata=0x80AA55CC:
  - LB: one mem_rstrb, mem_addr=0x4, rsp_rdata=0xFFFFFF80.
  - LBU: rsp_rdata=0x00000080.
  - Zero-wait latency is 3 cycles.
- SH at addr 0x0A, wdata=0x1234BEEF: mem_wmask=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x2, rsp_valid with rsp_rdata=0, rsp_err=0.
- LW at 0x06 (misaligned) and load funct3=011 (illegal): in each case no rstrb/wmask, rsp_err=1 in T0+1, rsp_rdata=0.
- LW at 0x20 with mem_busy held high 5 cycles, then mem_rdata=0xDEADBEEF:
  - rsp_valid in T0+8.
  - req_ready low throughout; a req_valid pulse during the stall produces no second transaction.
- Reset asserted during WAIT of a load:
  - Next cycle: IDLE with all outputs 0, no rsp_valid.
  - After resetn goes high, SW 0xCAFEF00D at 0x0 gives mem_wmask=1111 and mem_wdata=0xCAFEF00D.
- Back-to-back requests with req_valid held high: accepts occur exactly 4 cycles apart; one rsp_valid per accept.
